// File: rtl/sram_lsu_pkg.sv
// sram_lsu_pkg: access-size and FSM encodings shared by the load/store unit
package sram_lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RESP = 2'd2} state_e;
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    return size == SZ_B ? 3'd0 : size == SZ_H ? 3'd1 : size == SZ_W ? 3'd3 : 3'd7;
  endfunction
endpackage

// File: rtl/sram_lsu_if.sv
// sram_lsu_if: pipeline request/response and sram data-port signals of the load/store unit
interface sram_lsu_if #(parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              sram_en;
  logic [7:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [63:0]       sram_wdata;
  logic [63:0]       sram_rdata;
  modport master (
    output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata, resp_ready, sram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, sram_en, sram_we, sram_addr, sram_wdata
  );
  modport slave (
    input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata, resp_ready, sram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_lsu_align.sv
// sram_lsu_align: byte-lane strobe/data shift for stores, shift and sign/zero extend for loads
module sram_lsu_align
  import sram_lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [2:0]  i_st_off,
  input  logic [63:0] i_st_data,
  output logic [7:0]  o_st_we,
  output logic [63:0] o_st_data,
  input  logic [1:0]  i_ld_size,
  input  logic [2:0]  i_ld_off,
  input  logic        i_ld_signed,
  input  logic [63:0] i_ld_data,
  output logic [63:0] o_ld_data
);
  logic [7:0]  w_mask;
  logic [63:0] w_sh;
  always_comb begin
    w_mask = i_st_size == SZ_B ? 8'h01 : i_st_size == SZ_H ? 8'h03 : i_st_size == SZ_W ? 8'h0F : 8'hFF;
    o_st_we = w_mask << i_st_off;
    o_st_data = i_st_data << {i_st_off, 3'b0};
    w_sh = i_ld_data >> {i_ld_off, 3'b0};
    o_ld_data = i_ld_size == SZ_B ? {{56{i_ld_signed & w_sh[7]}}, w_sh[7:0]}
              : i_ld_size == SZ_H ? {{48{i_ld_signed & w_sh[15]}}, w_sh[15:0]}
              : i_ld_size == SZ_W ? {{32{i_ld_signed & w_sh[31]}}, w_sh[31:0]}
              : w_sh;
  end
endmodule

// File: rtl/sram_lsu.sv
// sram_lsu: single-outstanding load/store initiator for the data sram with misalignment errors
module sram_lsu
  import sram_lsu_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  sram_lsu_if.slave lsu
);
  state_e      r_state;
  state_e      w_next;
  logic [2:0]  r_off;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_err;
  logic [63:0] r_rdata;
  logic [2:0]  w_off;
  logic        w_acc;
  logic        w_err;
  logic        w_go;
  logic [7:0]  w_we;
  logic [63:0] w_wdata;
  logic [63:0] w_ldata;
  assign w_off = lsu.req_addr[2:0];
  sram_lsu_align u_align (
    .i_st_size   (lsu.req_size),
    .i_st_off    (w_off),
    .i_st_data   (lsu.req_wdata),
    .o_st_we     (w_we),
    .o_st_data   (w_wdata),
    .i_ld_size   (r_size),
    .i_ld_off    (r_off),
    .i_ld_signed (r_signed),
    .i_ld_data   (lsu.sram_rdata),
    .o_ld_data   (w_ldata)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // sram outputs only carry the request in its accept cycle; errors never reach the sram
  always_comb begin
    lsu.req_ready = r_state == IDLE && !rst;
    w_acc = lsu.req_valid && r_state == IDLE && !rst;
    w_err = ERR_ON_MISALIGN && (w_off & align_mask(lsu.req_size)) != 3'd0;
    w_go = w_acc && !w_err;
    lsu.sram_en = w_go;
    lsu.sram_we = w_go && lsu.req_wen ? w_we : 8'h00;
    lsu.sram_addr = w_go ? {lsu.req_addr[ADDR_W-1:3], 3'b0} : '0;
    lsu.sram_wdata = w_go && lsu.req_wen ? w_wdata : 64'h0;
    w_next = r_state == IDLE ? (!w_acc ? IDLE : (w_err || lsu.req_wen) ? RESP : RD_WAIT)
           : r_state == RD_WAIT ? RESP
           : lsu.resp_ready ? IDLE : RESP;
    lsu.resp_valid = r_state == RESP;
    lsu.resp_rdata = r_rdata;
    lsu.resp_err = r_err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_off <= 3'd0;
      r_size <= 2'd0;
      r_signed <= 1'b0;
      r_err <= 1'b0;
      r_rdata <= 64'h0;
    end else if (w_acc) begin
      r_off <= w_off;
      r_size <= lsu.req_size;
      r_signed <= lsu.req_signed;
      r_err <= w_err;
      r_rdata <= 64'h0;
    end else if (r_state == RD_WAIT) begin
      r_rdata <= w_ldata;
    end
  end
endmodule
